cpu_ctrl: RTL and testbench

Instruction sequencer for the 4-bit CPU. Owns the program counter and instruction register and fetches 16-bit instructions from instruction memory through a req/ack handshake. It presents each instruction to the combinational instruction decoder and gives the decoder a full cycle to settle. It then strobes the register-file write enable and selects the next PC: sequential, jump, or jump-if-zero.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_pc.sv | 30 +++
 rtl/cpu_ctrl.sv | 108 ++++++++++
 tb/tb_cpu_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit CPU sequencer.
// STEP_EN adds the single-step wait state to the FSM.
package cpu_pkg;

    localparam int INS_W    = 16;
    localparam int PC_W     = 4;
    localparam int HALT_BIT = 15;

    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
`ifdef STEP_EN
        S_HALT,
        S_STEP_WAIT
`else
        S_HALT
`endif
    } state_t;

    // High when the writeback must redirect the PC to the branch target.
    function automatic logic take_branch(
        input logic [2:0] op,
        input logic       z
    );
        return (op == OP_JMP) || ((op == OP_JZ) && z);
    endfunction

endpackage

// File: rtl/cpu_pc.sv
// 4-bit program counter: load has priority over increment.
// Increment wraps modulo 16.
module cpu_pc
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    logic [PC_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_ONE;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction sequencer: fetch, decode settle, exec, writeback.
// STEP_EN adds a step input and a STEP_WAIT state after writeback.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    output logic [PC_W-1:0]  IMEM_ADDR,
    input  logic             imem_ack,
    input  logic [INS_W-1:0] IMEM_DATA,
    output logic [INS_W-1:0] INS,
    input  logic             dec_write_en,
    input  logic [PC_W-1:0]  JMP,
    input  logic             zero,
`ifdef STEP_EN
    input  logic             step,
`endif
    output logic             rf_we,
    output logic [PC_W-1:0]  PC,
    output logic             busy,
    output logic             halted
);

    state_t           r_state;
    state_t           w_next;
    logic [INS_W-1:0] r_ins;
    logic [2:0]       w_op;
    logic             w_halt;
    logic             w_wb;
    logic             w_load;
    logic             w_inc;

    assign w_op   = r_ins[10:8];
    assign w_halt = r_ins[HALT_BIT];
    assign w_wb   = (r_state == S_WB);
    assign w_load = w_wb & ~w_halt & take_branch(w_op, zero);
    assign w_inc  = w_wb & ~w_halt & ~w_load;

    cpu_pc u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_inc    (w_inc),
        .i_target (JMP),
        .o_pc     (PC)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ins <= '0;
        end else if ((r_state == S_FETCH) && imem_ack) begin
            r_ins <= IMEM_DATA;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (imem_ack) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_WB: begin
                if (w_halt) begin
                    w_next = S_HALT;
                end else if (!run) begin
                    w_next = S_IDLE;
                end else begin
`ifdef STEP_EN
                    w_next = S_STEP_WAIT;
`else
                    w_next = S_FETCH;
`endif
                end
            end
`ifdef STEP_EN
            S_STEP_WAIT: begin
                if (step) begin
                    w_next = S_FETCH;
                end else if (!run) begin
                    w_next = S_IDLE;
                end
            end
`endif
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decode directly from state so async reset drops them at once.
    assign imem_req  = (r_state == S_FETCH);
    assign IMEM_ADDR = PC;
    assign INS       = r_ins;
    assign rf_we     = w_wb & dec_write_en & ~w_halt;
    assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed-vector bench for cpu_ctrl.
// STEP_EN also enables the single-step scenario.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] IMEM_DATA = 16'h0000;
    logic        dec_write_en = 1'b0;
    logic [3:0]  JMP = 4'h0;
    logic        zero = 1'b0;
`ifdef STEP_EN
    logic        step = 1'b1;
`endif
    logic        imem_req;
    logic [3:0]  IMEM_ADDR;
    logic [15:0] INS;
    logic        rf_we;
    logic [3:0]  PC;
    logic        busy;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    cpu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_req     (imem_req),
        .IMEM_ADDR    (IMEM_ADDR),
        .imem_ack     (imem_ack),
        .IMEM_DATA    (IMEM_DATA),
        .INS          (INS),
        .dec_write_en (dec_write_en),
        .JMP          (JMP),
        .zero         (zero),
`ifdef STEP_EN
        .step         (step),
`endif
        .rf_we        (rf_we),
        .PC           (PC),
        .busy         (busy),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // WB -> next fetch; in step builds step is held high so STEP_WAIT lasts one cycle.
    task automatic next_fetch;
        tick;
`ifdef STEP_EN
        tick;
`endif
    endtask

    // Memory word plus the decoder's view of it.
    task automatic set_ins(input logic [15:0] ins);
        IMEM_DATA = ins;
        JMP = ins[7:4];
        dec_write_en = !((ins[10:8] == 3'b100) || (ins[10:8] == 3'b011));
    endtask

    // Starts in a FETCH cycle; returns in the first cycle after WB.
    task automatic run_instr(
        input  logic [15:0] ins,
        input  int          stalls,
        input  logic        z,
        input  logic        drop,
        output logic        we_wb
    );
        set_ins(ins);
        zero = z;
        imem_ack = 1'b0;
        repeat (stalls) tick;
        imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        if (drop) run = 1'b0;
        tick;
        tick;
        we_wb = rf_we;
        if (drop || ins[15]) tick;
        else next_fetch;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req got %b exp 0", imem_req);
        end
        n_vec++;
        if (PC !== 4'd0 || INS !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_regs got PC=%0d INS=%h exp 0/0000", PC, INS);
        end
        n_vec++;
        if ({rf_we, busy, halted} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got %b exp 000", {rf_we, busy, halted});
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_sequential;
        logic [4:0] wev;
        run = 1'b1;
        set_ins(16'h0112);
        zero = 1'b0;
        imem_ack = 1'b1;
        tick;
        n_vec++;
        if (imem_req !== 1'b1 || IMEM_ADDR !== 4'd0) begin
            n_err++;
            $display("FAIL seq_fetch got req=%b addr=%0d exp 1/0", imem_req, IMEM_ADDR);
        end
        wev[0] = rf_we;
        tick;
        wev[1] = rf_we;
        n_vec++;
        if (INS !== 16'h0112 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL seq_ins got INS=%h req=%b exp 0112/0", INS, imem_req);
        end
        tick;
        wev[2] = rf_we;
        tick;
        wev[3] = rf_we;
        n_vec++;
        if (PC !== 4'd0) begin
            n_err++;
            $display("FAIL seq_pc_wb got %0d exp 0", PC);
        end
        imem_ack = 1'b0;
        next_fetch;
        wev[4] = rf_we;
        n_vec++;
        if (wev !== 5'b01000) begin
            n_err++;
            $display("FAIL seq_rf_we got %b exp 01000", wev);
        end
        n_vec++;
        if (imem_req !== 1'b1 || PC !== 4'd1) begin
            n_err++;
            $display("FAIL seq_next got req=%b PC=%0d exp 1/1", imem_req, PC);
        end
    endtask

    task automatic test_stall;
        logic       we;
        logic       stable;
        logic [15:0] ins5;
        logic [6:0] wev;
        run_instr(16'h0450, 0, 1'b0, 1'b0, we);
        n_vec++;
        if (PC !== 4'd5) begin
            n_err++;
            $display("FAIL stall_setup got PC=%0d exp 5", PC);
        end
        set_ins(16'h0123);
        imem_ack = 1'b0;
        stable = 1'b1;
        ins5 = 16'h0000;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4 && (IMEM_ADDR !== 4'd5 || imem_req !== 1'b1 || INS !== 16'h0450))
                stable = 1'b0;
            if (c == 5) ins5 = INS;
            wev[c-1] = rf_we;
            imem_ack = (c == 4);
            if (c < 7) tick;
        end
        imem_ack = 1'b0;
        n_vec++;
        if (stable !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold got %b exp 1", stable);
        end
        n_vec++;
        if (ins5 !== 16'h0123) begin
            n_err++;
            $display("FAIL stall_ins got %h exp 0123", ins5);
        end
        n_vec++;
        if (wev !== 7'b1000000) begin
            n_err++;
            $display("FAIL stall_wb got %b exp 1000000", wev);
        end
        next_fetch;
        n_vec++;
        if (PC !== 4'd6) begin
            n_err++;
            $display("FAIL stall_pc got %0d exp 6", PC);
        end
    endtask

    task automatic test_branch;
        logic we;
        run_instr(16'h04A0, 0, 1'b0, 1'b0, we);
        n_vec++;
        if (PC !== 4'd10 || we !== 1'b0) begin
            n_err++;
            $display("FAIL jmp got PC=%0d we=%b exp 10/0", PC, we);
        end
        run_instr(16'h03C0, 2, 1'b0, 1'b0, we);
        n_vec++;
        if (PC !== 4'd11 || we !== 1'b0) begin
            n_err++;
            $display("FAIL jz_nt got PC=%0d we=%b exp 11/0", PC, we);
        end
        run_instr(16'h03C0, 0, 1'b1, 1'b0, we);
        n_vec++;
        if (PC !== 4'd12 || we !== 1'b0) begin
            n_err++;
            $display("FAIL jz_t got PC=%0d we=%b exp 12/0", PC, we);
        end
        zero = 1'b0;
    endtask

    task automatic test_wrap;
        logic we;
        run_instr(16'h04F0, 0, 1'b0, 1'b0, we);
        n_vec++;
        if (PC !== 4'd15) begin
            n_err++;
            $display("FAIL wrap_setup got PC=%0d exp 15", PC);
        end
        run_instr(16'h0112, 1, 1'b0, 1'b0, we);
        n_vec++;
        if (PC !== 4'd0 || we !== 1'b1) begin
            n_err++;
            $display("FAIL wrap got PC=%0d we=%b exp 0/1", PC, we);
        end
    endtask

    task automatic test_run_drop;
        logic we;
        logic req_seen;
        run_instr(16'h0112, 0, 1'b0, 1'b1, we);
        n_vec++;
        if (busy !== 1'b0 || PC !== 4'd1 || we !== 1'b1) begin
            n_err++;
            $display("FAIL drop_done got busy=%b PC=%0d we=%b exp 0/1/1", busy, PC, we);
        end
        req_seen = 1'b0;
        repeat (3) begin
            tick;
            req_seen |= imem_req;
        end
        n_vec++;
        if (req_seen !== 1'b0) begin
            n_err++;
            $display("FAIL drop_idle got req=%b exp 0", req_seen);
        end
        run = 1'b1;
        tick;
        n_vec++;
        if (imem_req !== 1'b1 || IMEM_ADDR !== 4'd1) begin
            n_err++;
            $display("FAIL drop_resume got req=%b addr=%0d exp 1/1", imem_req, IMEM_ADDR);
        end
    endtask

    task automatic test_halt;
        logic we;
        logic req_seen;
        run_instr(16'h8000, 0, 1'b0, 1'b0, we);
        n_vec++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL halt_flags got halted=%b busy=%b exp 1/0", halted, busy);
        end
        n_vec++;
        if (PC !== 4'd1 || we !== 1'b0) begin
            n_err++;
            $display("FAIL halt_pc got PC=%0d we=%b exp 1/0", PC, we);
        end
        imem_ack = 1'b1;
        req_seen = 1'b0;
        repeat (6) begin
            tick;
            req_seen |= imem_req;
        end
        imem_ack = 1'b0;
        n_vec++;
        if (req_seen !== 1'b0 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_sticky got req=%b halted=%b exp 0/1", req_seen, halted);
        end
    endtask

    task automatic test_reset_midfetch;
        logic we;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        run = 1'b1;
        tick;
        tick;
        run_instr(16'h0470, 0, 1'b0, 1'b0, we);
        n_vec++;
        if (imem_req !== 1'b1 || PC !== 4'd7 || INS !== 16'h0470) begin
            n_err++;
            $display("FAIL mid_setup got req=%b PC=%0d INS=%h exp 1/7/0470", imem_req, PC, INS);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || PC !== 4'd0) begin
            n_err++;
            $display("FAIL mid_async got req=%b PC=%0d exp 0/0", imem_req, PC);
        end
        n_vec++;
        if (INS !== 16'h0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_state got INS=%h busy=%b exp 0000/0", INS, busy);
        end
        run = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

`ifdef STEP_EN
    task automatic test_step;
        logic req_seen;
        step = 1'b0;
        run = 1'b1;
        set_ins(16'h0112);
        imem_ack = 1'b1;
        tick;
        tick;
        imem_ack = 1'b0;
        tick;
        tick;
        tick;
        n_vec++;
        if (busy !== 1'b1 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL step_wait got busy=%b req=%b exp 1/0", busy, imem_req);
        end
        req_seen = 1'b0;
        repeat (3) begin
            tick;
            req_seen |= imem_req;
        end
        n_vec++;
        if (req_seen !== 1'b0) begin
            n_err++;
            $display("FAIL step_hold got req=%b exp 0", req_seen);
        end
        step = 1'b1;
        tick;
        step = 1'b0;
        n_vec++;
        if (imem_req !== 1'b1 || IMEM_ADDR !== 4'd1) begin
            n_err++;
            $display("FAIL step_go got req=%b addr=%0d exp 1/1", imem_req, IMEM_ADDR);
        end
        step = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_sequential;
        test_stall;
        test_branch;
        test_wrap;
        test_run_drop;
        test_halt;
        test_reset_midfetch;
`ifdef STEP_EN
        test_step;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
